apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ internal requesters using round-robin arbitration.
- Sequences each granted transfer through the APB IDLE/SETUP/ACCESS phases and waits on PREADY.
- Decodes PADDR into a one-hot PSEL over SLV_COUNT slaves.
- Sits between the bus-functional requesters and the master side of the APB interface.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ADDR_W, `D_ADDR_WIDTH, PADDR width.
- DATA_W, `D_DATA_WIDTH, PWDATA/PRDATA width.
- SLV_COUNT, `D_SLV_COUNT, number of PSEL lines.
- REGION_BITS, 12, log2 of bytes per slave region. Slave index = addr >> REGION_BITS.

Ports:
- PCLK  in  1  bus clock
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until granted
- req_write  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened, same packing
- req_gnt  out  NUM_REQ  one-hot, combinational; request fields are sampled on this cycle
- rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse, registered
- rsp_rdata  out  DATA_W  read data; valid only with rsp_valid
- rsp_err  out  1  decode error; valid only with rsp_valid
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PSEL  out  SLV_COUNT  APB one-hot slave select
- PENABLE  out  1  APB access phase
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  APB slave ready
- PRDATA  in  DATA_W  APB read data

Behaviour:
- Clock is PCLK. Reset is PRESETn, asynchronous and active-low.
- In reset:
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err are all 0.
  - req_gnt is 0 while PRESETn is low.
- All APB outputs are registered.
- FSM IDLE:
  - If any req_valid is set, select the winner by round-robin, searching from rr_ptr+1 upward (wrapping).
  - Assert req_gnt[winner] this cycle and set rr_ptr=winner.
  - Latch addr/write/wdata into PADDR/PWRITE/PWDATA.
  - Decode the slave index from the latched address:
    - In range: PSEL[idx]=1, PENABLE=0, next state SETUP.
    - Out of range (idx >= SLV_COUNT): no APB activity. Next cycle rsp_valid[winner]=1, rsp_err=1, rsp_rdata=0. State stays IDLE; the next grant is allowed in the cycle after the grant.
- FSM SETUP: unconditionally set PENABLE=1, next state ACCESS.
- FSM ACCESS:
  - PREADY=0: hold every APB output stable. There is no timeout.
  - PREADY=1: next cycle rsp_valid[owner]=1, rsp_err=0. rsp_rdata = PRDATA for reads, 0 for writes. PENABLE goes to 0.
  - In the same PREADY cycle, arbitrate again:
    - A valid request exists: grant it (req_gnt this cycle), load its fields, go directly to SETUP (back-to-back transfer, PSEL stays asserted if the same slave).
    - No request: PSEL=0, go to IDLE.
- Minimum latency, grant to rsp_valid: 3 cycles (grant, SETUP, ACCESS with PREADY=1, response).
- Throughput: one transfer per 2 cycles when PREADY is tied high.
- Round-robin:
  - The requester just granted has lowest priority next.
  - A single requester may be granted on consecutive opportunities.
  - No requester waits more than NUM_REQ-1 other grants.
- req_gnt is asserted only when state allows acceptance (IDLE, or ACCESS with PREADY=1). It is never asserted in SETUP.
- A requester dropping req_valid before its grant is legal; its request is simply not serviced.
- Reset asserted mid-transfer: all outputs drop immediately and no rsp_valid is generated for the aborted transfer.
- After PREADY in ACCESS, the next PSEL is never unselected and reselected in the same cycle. A change of slave takes effect at the SETUP edge.

Decomposition:
- Package apb_pkg:
  - typedef apb_state_e {IDLE, SETUP, ACCESS}.
  - function decode_psel(addr) returning a one-hot vector plus a decode-error flag.
  - Width constants derived from the defines.
- Sub-module apb_rr_arbiter (parameter N):
  - Inputs: req[N], ptr, enable.
  - Outputs: gnt one-hot, gnt_idx.
  - Purely combinational rotate / priority-encode / rotate-back.
  - rr_ptr is owned by the parent.

Test Plan:
- Single read: req 1 reads addr 0x0000_1010, slave returns 0xDEAD_BEEF with PREADY high. Expect PSEL=0b0010, SETUP then ACCESS, rsp_valid[1] 3 cycles after grant, rsp_rdata=0xDEAD_BEEF.
- Wait states: write 0x55AA to slave 0, PREADY low for 4 cycles. Expect PADDR/PWDATA/PSEL/PENABLE stable throughout, rsp_valid[0] one cycle after PREADY rises, rsp_err=0.
- Round-robin fairness: all 4 requesters hold valid continuously for 8 transfers with PREADY=1. Expect grant order 0,1,2,3,0,1,2,3, back-to-back SETUP with no IDLE cycle.
- Decode error: addr = SLV_COUNT<<REGION_BITS. Expect PSEL stays 0 and PENABLE stays 0, rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after the grant.
- Reset mid-transfer: PRESETn dropped during ACCESS with PREADY=0. Expect all outputs 0 asynchronously and no rsp_valid. After release, first grant goes to req 0 (rr_ptr=NUM_REQ-1).
- Late withdrawal: req 2 valid, then deasserted while req 0 is in ACCESS; req 3 still valid. Expect the next grant to go to req 3 and no transfer for req 2.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types, width constants and the PADDR-to-PSEL decoder used by the
// APB master arbiter.
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif
`ifndef D_SLV_COUNT
`define D_SLV_COUNT 4
`endif

package apb_pkg;

    localparam int APB_ADDR_W    = `D_ADDR_WIDTH;
    localparam int APB_DATA_W    = `D_DATA_WIDTH;
    localparam int APB_SLV_COUNT = `D_SLV_COUNT;
    localparam int APB_SLV_IDX_W = (APB_SLV_COUNT > 1) ? $clog2(APB_SLV_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_SLV_COUNT-1:0] psel;
        logic                     err;
    } apb_dec_t;

    // Slave index is the address above the region bits; anything past the
    // last slave is a decode error with no select asserted.
    function automatic apb_dec_t decode_psel(input logic [63:0] addr,
                                             input int unsigned region_bits);
        logic [63:0] idx;
        apb_dec_t    d;
        idx    = addr >> region_bits;
        d.psel = '0;
        d.err  = 1'b0;
        if (idx >= 64'(APB_SLV_COUNT)) begin
            d.err = 1'b1;
        end else begin
            d.psel[idx[APB_SLV_IDX_W-1:0]] = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the slave fabric.
interface apb_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SLV_COUNT = 4
) ();
    logic [ADDR_W-1:0]    PADDR;
    logic                 PWRITE;
    logic [SLV_COUNT-1:0] PSEL;
    logic                 PENABLE;
    logic [DATA_W-1:0]    PWDATA;
    logic                 PREADY;
    logic [DATA_W-1:0]    PRDATA;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 (wrapping)
// and returns the first requester found as one-hot plus its index.
module apb_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters,
// with IDLE/SETUP/ACCESS sequencing and one-hot PSEL address decode.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int SLV_COUNT   = APB_SLV_COUNT,
    parameter int REGION_BITS = 12
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    apb_if.master                     apb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [SLV_COUNT-1:0] psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 err_pend_q, err_pend_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 arb_en;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [NUM_REQ-1:0]   owner_oh;
    apb_dec_t             dec;

    // A decode-error winner picked at the end of ACCESS would collide with the
    // response just issued, so its error reply is deferred one cycle and
    // arbitration pauses for that cycle.
    assign arb_en = PRESETn &&
                    (((state_q == IDLE) && !err_pend_q) ||
                     ((state_q == ACCESS) && apb.PREADY));

    apb_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign dec       = decode_psel(64'(sel_addr), REGION_BITS);
    assign owner_oh  = NUM_REQ'(1) << rr_ptr_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        err_pend_d  = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (err_pend_q) begin
                    rsp_valid_d = owner_oh;
                    rsp_err_d   = 1'b1;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    rsp_valid_d = owner_oh;
                    rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
                    penable_d   = 1'b0;
                    psel_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (|gnt) begin
            rr_ptr_d  = gnt_idx;
            paddr_d   = sel_addr;
            pwrite_d  = req_write[gnt_idx];
            pwdata_d  = sel_wdata;
            penable_d = 1'b0;
            if (dec.err) begin
                psel_d  = '0;
                state_d = IDLE;
                if (state_q == ACCESS) begin
                    err_pend_d = 1'b1;
                end else begin
                    rsp_valid_d = NUM_REQ'(1) << gnt_idx;
                    rsp_err_d   = 1'b1;
                end
            end else begin
                psel_d  = SLV_COUNT'(dec.psel);
                state_d = SETUP;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            err_pend_q  <= err_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_gnt     = gnt;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a per-cycle vector table plus
// hand-written sequences for wait states, fairness and mid-transfer reset.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SC = 4;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic [NR-1:0]    req_valid, req_write, req_gnt, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;

    apb_if #(.ADDR_W(AW), .DATA_W(DW), .SLV_COUNT(SC)) apb ();

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .SLV_COUNT(SC), .REGION_BITS(12)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [31:0] addr;
        logic        pready;
        logic [31:0] prdata;
        logic [3:0]  gnt;
        logic [3:0]  psel;
        logic        pen;
        logic [3:0]  rspv;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_all_addr(input logic [31:0] a);
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        PRESETn    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        apb.PREADY = 1'b0;
        apb.PRDATA = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
    endtask

    initial begin
        // cycle table: valid, write, addr, pready, prdata | gnt, psel, pen, rspv, err, rdata
        tv[0]  = '{4'b0010, 4'b0000, 32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tv[1]  = '{4'b0000, 4'b0000, 32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 32'h0};
        tv[2]  = '{4'b0000, 4'b0000, 32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0, 32'h0};
        tv[3]  = '{4'b0000, 4'b0000, 32'h0000_1010, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 32'hDEAD_BEEF};
        tv[4]  = '{4'b0100, 4'b0000, 32'h0000_4000, 1'b0, 32'h0,         4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tv[5]  = '{4'b0000, 4'b0000, 32'h0000_4000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 32'h0};
        tv[6]  = '{4'b0001, 4'b1111, 32'h0000_0000, 1'b0, 32'h0,         4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tv[7]  = '{4'b0100, 4'b1111, 32'h0000_0000, 1'b0, 32'h0,         4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0};
        tv[8]  = '{4'b1100, 4'b1111, 32'h0000_0000, 1'b0, 32'h0,         4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0};
        tv[9]  = '{4'b1000, 4'b0000, 32'h0000_0000, 1'b1, 32'h0,         4'b1000, 4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0};
        tv[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 32'h0,         4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 32'h0};
        tv[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 32'h1234_5678, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0};
        tv[12] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 32'h1234_5678};

        req_valid  = 4'b1111;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        apb.PREADY = 1'b0;
        apb.PRDATA = '0;
        for (int i = 0; i < NR; i++) req_wdata[i*DW +: DW] = 32'h1000 + i;

        // outputs while held in reset, requests pending
        #3;
        chk("rst_gnt", req_gnt, 4'b0000);
        chk("rst_psel", apb.PSEL, 4'b0000);
        chk("rst_penable", apb.PENABLE, 1'b0);
        chk("rst_paddr_pwrite_pwdata", {apb.PADDR, apb.PWRITE, apb.PWDATA}, 65'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 37'h0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req_valid  = tv[i].valid;
            req_write  = tv[i].write;
            set_all_addr(tv[i].addr);
            apb.PREADY = tv[i].pready;
            apb.PRDATA = tv[i].prdata;
            #1;
            chk($sformatf("tv%0d_gnt", i), req_gnt, tv[i].gnt);
            chk($sformatf("tv%0d_psel", i), apb.PSEL, tv[i].psel);
            chk($sformatf("tv%0d_penable", i), apb.PENABLE, tv[i].pen);
            chk($sformatf("tv%0d_rsp_valid", i), rsp_valid, tv[i].rspv);
            if (tv[i].rspv != 4'b0000) begin
                chk($sformatf("tv%0d_rsp_err", i), rsp_err, tv[i].err);
                chk($sformatf("tv%0d_rsp_rdata", i), rsp_rdata, tv[i].rdata);
            end
            tick();
        end

        // wait states on a write to slave 0
        do_reset();
        req_addr[0 +: AW]  = 32'h0000_0004;
        req_wdata[0 +: DW] = 32'h0000_55AA;
        req_write  = 4'b0001;
        req_valid  = 4'b0001;
        #1;
        chk("ws_gnt", req_gnt, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("ws_setup", {apb.PSEL, apb.PENABLE}, {4'b0001, 1'b0});
        tick();
        for (int w = 0; w < 4; w++) begin
            #1;
            chk($sformatf("ws%0d_paddr", w), apb.PADDR, 32'h0000_0004);
            chk($sformatf("ws%0d_pwdata", w), apb.PWDATA, 32'h0000_55AA);
            chk($sformatf("ws%0d_psel_pen_pwrite", w), {apb.PSEL, apb.PENABLE, apb.PWRITE}, {4'b0001, 1'b1, 1'b1});
            chk($sformatf("ws%0d_rsp_valid", w), rsp_valid, 4'b0000);
            tick();
        end
        apb.PREADY = 1'b1;
        #1;
        chk("ws_ready_rsp_valid", rsp_valid, 4'b0000);
        tick();
        apb.PREADY = 1'b0;
        #1;
        chk("ws_rsp_valid", rsp_valid, 4'b0001);
        chk("ws_rsp_err", rsp_err, 1'b0);
        chk("ws_idle", {apb.PSEL, apb.PENABLE}, {4'b0000, 1'b0});
        tick();

        // fairness with all requesters pending and PREADY tied high
        do_reset();
        set_all_addr(32'h0000_2000);
        req_write  = '0;
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'hA5A5_0000;
        req_valid  = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            logic [3:0] e_gnt, e_rspv, e_psel;
            logic       e_pen;
            #1;
            e_gnt  = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
            e_pen  = (c >= 2) && (c % 2 == 0);
            e_psel = (c == 0) ? 4'b0000 : 4'b0100;
            e_rspv = (c >= 3 && c % 2 == 1) ? 4'(1 << (((c - 3) / 2) % 4)) : 4'b0000;
            chk($sformatf("rr%0d_gnt", c), req_gnt, e_gnt);
            chk($sformatf("rr%0d_penable", c), apb.PENABLE, e_pen);
            chk($sformatf("rr%0d_psel", c), apb.PSEL, e_psel);
            chk($sformatf("rr%0d_rsp_valid", c), rsp_valid, e_rspv);
            tick();
        end
        req_valid = '0;

        // reset dropped in ACCESS with PREADY low
        do_reset();
        set_all_addr(32'h0000_1000);
        apb.PRDATA = 32'hCAFE_F00D;
        req_valid  = 4'b0010;
        #1;
        chk("mr_gnt", req_gnt, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("mr_access", {apb.PSEL, apb.PENABLE}, {4'b0010, 1'b1});
        #2;
        PRESETn    = 1'b0;
        req_valid  = 4'b1111;
        apb.PREADY = 1'b1;
        #1;
        chk("mr_psel_pen", {apb.PSEL, apb.PENABLE}, 5'b0);
        chk("mr_paddr_pwrite_pwdata", {apb.PADDR, apb.PWRITE, apb.PWDATA}, 65'h0);
        chk("mr_gnt_in_reset", req_gnt, 4'b0000);
        chk("mr_rsp", {rsp_valid, rsp_err, rsp_rdata}, 37'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn   = 1'b1;
        req_valid = '0;
        tick();
        chk("mr_no_rsp0", rsp_valid, 4'b0000);
        tick();
        chk("mr_no_rsp1", rsp_valid, 4'b0000);
        req_valid = 4'b1111;
        #1;
        chk("mr_first_gnt", req_gnt, 4'b0001);
        tick();
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
